// File: rtl/multdiv_controller_pkg.sv
// Shared constants for the multdiv sequencing controller: FSM encoding,
// instruction decode fields, exception writeback values and the watchdog limit.
package multdiv_controller_pkg;

    typedef logic [1:0] md_state_t;

    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_RUN  = 2'd1;
    localparam md_state_t ST_DONE = 2'd2;

    localparam logic [4:0] OPCODE_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_OP_MULT  = 5'b00110;
    localparam logic [4:0] ALU_OP_DIV   = 5'b00111;

    localparam logic [4:0]  REG_RSTATUS = 5'd30;
    localparam logic [31:0] EXC_MULT    = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;

    localparam int          CNT_W         = 6;
    localparam logic [5:0]  TIMEOUT_LIMIT = 6'd63;

endpackage

// File: rtl/multdiv_controller_md_cycle_counter.sv
// Cycle counter for an in-flight multdiv operation; clear wins over enable.
module md_cycle_counter
    import multdiv_controller_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multdiv_controller.sv
// Sequences one mult/div operation at a time: accepts from DX, starts the unit,
// watches for completion, flush or watchdog expiry, and issues the writeback.
//
// state | meaning
// IDLE  | no operation in flight; accepts a mult/div from DX
// RUN   | unit busy; pipeline stalled, cycle counter running
// DONE  | single-cycle completion strobe and writeback request
module multdiv_controller
    import multdiv_controller_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_ir,
    input  logic        dx_valid,
    input  logic        flush,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    output logic        multdiv_is_running,
    output logic        multdiv_result_ready,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout
);

    md_state_t        state;
    logic [CNT_W-1:0] count;
    logic             is_mult;
    logic             is_div;
    logic             accept;
    logic             op_div_q;
    logic [4:0]       rd_q;
    logic             exc_q;
    logic             unused_ir;

    assign unused_ir = ^{dx_ir[21:7], dx_ir[1:0]};

    assign is_mult = (dx_ir[31:27] == OPCODE_RTYPE) && (dx_ir[6:2] == ALU_OP_MULT);
    assign is_div  = (dx_ir[31:27] == OPCODE_RTYPE) && (dx_ir[6:2] == ALU_OP_DIV);
    assign accept  = (state == ST_IDLE) && dx_valid && (is_mult || is_div) && !flush;

    md_cycle_counter u_cycle_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (state != ST_RUN),
        .enable (state == ST_RUN),
        .count  (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            ctrl_mult    <= 1'b0;
            ctrl_div     <= 1'b0;
            timeout      <= 1'b0;
            op_div_q     <= 1'b0;
            rd_q         <= '0;
            exc_q        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            md_operand_a <= '0;
            md_operand_b <= '0;
        end else begin
            // start pulses are registered so they land in the first RUN cycle only
            ctrl_mult <= accept && is_mult;
            ctrl_div  <= accept && is_div;
            timeout   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        md_operand_a <= operand_a;
                        md_operand_b <= operand_b;
                        rd_q         <= dx_ir[26:22];
                        op_div_q     <= is_div;
                        state        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (md_ready) begin
                        state <= ST_DONE;
                        exc_q <= md_exception;
                        if (md_exception) begin
                            wb_rd   <= REG_RSTATUS;
                            wb_data <= op_div_q ? EXC_DIV : EXC_MULT;
                        end else begin
                            wb_rd   <= rd_q;
                            wb_data <= md_result;
                        end
                    end else if (count == TIMEOUT_LIMIT) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign multdiv_is_running   = (state == ST_RUN);
    assign multdiv_result_ready = (state == ST_DONE);
    // a clean result targeting r0 is dropped; exceptions always write rstatus
    assign wb_en = (state == ST_DONE) && ((wb_rd != 5'd0) || exc_q);

endmodule

// File: tb/tb_multdiv_controller.sv
// Directed bench for multdiv_controller: one task per scenario, hand-computed
// expected values, single summary line at the end.
module tb_multdiv_controller;

    logic        clock;
    logic        reset;
    logic [31:0] dx_ir;
    logic        dx_valid;
    logic        flush;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] md_operand_a;
    logic [31:0] md_operand_b;
    logic        multdiv_is_running;
    logic        multdiv_result_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    multdiv_controller dut (
        .clock                (clock),
        .reset                (reset),
        .dx_ir                (dx_ir),
        .dx_valid             (dx_valid),
        .flush                (flush),
        .operand_a            (operand_a),
        .operand_b            (operand_b),
        .md_result            (md_result),
        .md_exception         (md_exception),
        .md_ready             (md_ready),
        .ctrl_mult            (ctrl_mult),
        .ctrl_div             (ctrl_div),
        .md_operand_a         (md_operand_a),
        .md_operand_b         (md_operand_b),
        .multdiv_is_running   (multdiv_is_running),
        .multdiv_result_ready (multdiv_result_ready),
        .wb_en                (wb_en),
        .wb_rd                (wb_rd),
        .wb_data              (wb_data),
        .timeout              (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] make_ir(input logic [4:0] rd, input logic [4:0] alu);
        return {5'b00000, rd, 15'd0, alu, 2'b00};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one instruction in DX for a single cycle; returns just after the accept edge.
    task automatic issue(input logic [4:0] alu, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
        dx_ir     = make_ir(rd, alu);
        dx_valid  = 1'b1;
        operand_a = a;
        operand_b = b;
        step();
        dx_valid  = 1'b0;
        dx_ir     = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++; if (multdiv_is_running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", multdiv_is_running); end
        n_cmp++; if ({ctrl_mult, ctrl_div, multdiv_result_ready, wb_en, timeout} !== 5'b0) begin n_bad++; $display("FAIL reset_strobes: got %b want 00000", {ctrl_mult, ctrl_div, multdiv_result_ready, wb_en, timeout}); end
        n_cmp++; if ({wb_rd, wb_data, md_operand_a, md_operand_b} !== 101'd0) begin n_bad++; $display("FAIL reset_data: wb_rd=%0d wb_data=%0h a=%0h b=%0h want all 0", wb_rd, wb_data, md_operand_a, md_operand_b); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_mult_basic();
        int run_cycles;
        issue(ALU_MULT, 5'd5, 32'd7, 32'd6);
        n_cmp++; if ({ctrl_mult, ctrl_div} !== 2'b10) begin n_bad++; $display("FAIL mult_start_pulse: got mult/div=%b want 10", {ctrl_mult, ctrl_div}); end
        n_cmp++; if ({md_operand_a, md_operand_b} !== {32'd7, 32'd6}) begin n_bad++; $display("FAIL mult_operands: got %0d,%0d want 7,6", md_operand_a, md_operand_b); end
        run_cycles = multdiv_is_running ? 1 : 0;
        step();
        n_cmp++; if ({ctrl_mult, ctrl_div} !== 2'b00) begin n_bad++; $display("FAIL mult_pulse_width: got mult/div=%b want 00", {ctrl_mult, ctrl_div}); end
        if (multdiv_is_running) run_cycles++;
        for (int i = 3; i <= 17; i++) begin
            step();
            if (multdiv_is_running) run_cycles++;
        end
        md_ready  = 1'b1;
        md_result = 32'd42;
        step();
        md_ready  = 1'b0;
        md_result = 32'd0;
        n_cmp++; if (run_cycles !== 17) begin n_bad++; $display("FAIL mult_run_cycles: got %0d want 17", run_cycles); end
        n_cmp++; if ({multdiv_is_running, multdiv_result_ready, wb_en} !== 3'b011) begin n_bad++; $display("FAIL mult_done_flags: run/ready/wb_en=%b want 011", {multdiv_is_running, multdiv_result_ready, wb_en}); end
        n_cmp++; if ({wb_rd, wb_data} !== {5'd5, 32'd42}) begin n_bad++; $display("FAIL mult_wb: got rd=%0d data=%0d want rd=5 data=42", wb_rd, wb_data); end
        // a mult sitting in DX during DONE must not start a new operation
        dx_ir    = make_ir(5'd6, ALU_MULT);
        dx_valid = 1'b1;
        step();
        dx_valid = 1'b0;
        dx_ir    = 32'd0;
        n_cmp++; if ({multdiv_is_running, ctrl_mult, multdiv_result_ready, wb_en} !== 4'b0000) begin n_bad++; $display("FAIL done_no_accept: run/mult/ready/wb_en=%b want 0000", {multdiv_is_running, ctrl_mult, multdiv_result_ready, wb_en}); end
        step();
    endtask

    task automatic test_div_by_zero();
        issue(ALU_DIV, 5'd3, 32'd9, 32'd0);
        n_cmp++; if ({ctrl_mult, ctrl_div} !== 2'b01) begin n_bad++; $display("FAIL div_start_pulse: got mult/div=%b want 01", {ctrl_mult, ctrl_div}); end
        step();
        step();
        md_ready     = 1'b1;
        md_exception = 1'b1;
        md_result    = 32'hDEAD_BEEF;
        step();
        md_ready     = 1'b0;
        md_exception = 1'b0;
        md_result    = 32'd0;
        n_cmp++; if ({multdiv_result_ready, wb_en, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd30, 32'd5}) begin n_bad++; $display("FAIL div0_wb: ready=%b wb_en=%b rd=%0d data=%0d want 1 1 30 5", multdiv_result_ready, wb_en, wb_rd, wb_data); end
        step();
    endtask

    task automatic test_mult_overflow();
        issue(ALU_MULT, 5'd0, 32'h7FFF_FFFF, 32'd2);
        md_ready     = 1'b1;
        md_exception = 1'b1;
        step();
        md_ready     = 1'b0;
        md_exception = 1'b0;
        n_cmp++; if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd30, 32'd4}) begin n_bad++; $display("FAIL mult_ovf_wb: wb_en=%b rd=%0d data=%0d want 1 30 4", wb_en, wb_rd, wb_data); end
        step();
    endtask

    task automatic test_rd_zero();
        issue(ALU_MULT, 5'd0, 32'd11, 32'd3);
        step();
        md_ready  = 1'b1;
        md_result = 32'd33;
        step();
        md_ready  = 1'b0;
        md_result = 32'd0;
        n_cmp++; if ({multdiv_result_ready, wb_en} !== 2'b10) begin n_bad++; $display("FAIL rd0_flags: ready/wb_en=%b want 10", {multdiv_result_ready, wb_en}); end
        n_cmp++; if ({wb_rd, wb_data} !== {5'd0, 32'd33}) begin n_bad++; $display("FAIL rd0_data: rd=%0d data=%0d want 0 33", wb_rd, wb_data); end
        step();
    endtask

    task automatic test_flush();
        // flush alongside a valid mult in IDLE blocks acceptance
        dx_ir    = make_ir(5'd7, ALU_MULT);
        dx_valid = 1'b1;
        flush    = 1'b1;
        step();
        dx_valid = 1'b0;
        flush    = 1'b0;
        n_cmp++; if ({ctrl_mult, multdiv_is_running} !== 2'b00) begin n_bad++; $display("FAIL flush_accept: mult/run=%b want 00", {ctrl_mult, multdiv_is_running}); end
        issue(ALU_MULT, 5'd7, 32'd2, 32'd2);
        step();
        flush     = 1'b1;
        md_ready  = 1'b1;
        md_result = 32'd4;
        step();
        flush    = 1'b0;
        md_ready = 1'b0;
        n_cmp++; if ({multdiv_is_running, multdiv_result_ready, wb_en} !== 3'b000) begin n_bad++; $display("FAIL flush_priority: run/ready/wb_en=%b want 000", {multdiv_is_running, multdiv_result_ready, wb_en}); end
        step();
        n_cmp++; if ({multdiv_result_ready, wb_en} !== 2'b00) begin n_bad++; $display("FAIL flush_no_done: ready/wb_en=%b want 00", {multdiv_result_ready, wb_en}); end
    endtask

    task automatic test_timeout();
        int cycles;
        issue(ALU_DIV, 5'd9, 32'd100, 32'd3);
        cycles = 0;
        while (cycles < 100) begin
            step();
            cycles++;
            if (timeout) break;
        end
        // counter values 0..63 occupy 64 RUN cycles; the pulse follows the last
        n_cmp++; if (cycles !== 64) begin n_bad++; $display("FAIL timeout_latency: got %0d cycles want 64", cycles); end
        n_cmp++; if ({timeout, multdiv_is_running, multdiv_result_ready, wb_en} !== 4'b1000) begin n_bad++; $display("FAIL timeout_state: to/run/ready/wb_en=%b want 1000", {timeout, multdiv_is_running, multdiv_result_ready, wb_en}); end
        md_ready     = 1'b1;
        md_exception = 1'b1;
        step();
        md_ready     = 1'b0;
        md_exception = 1'b0;
        n_cmp++; if ({timeout, multdiv_result_ready, wb_en, multdiv_is_running} !== 4'b0000) begin n_bad++; $display("FAIL idle_ignore_ready: to/ready/wb_en/run=%b want 0000", {timeout, multdiv_result_ready, wb_en, multdiv_is_running}); end
    endtask

    task automatic test_reset_mid_op();
        issue(ALU_MULT, 5'd9, 32'd3, 32'd4);
        step();
        step();
        reset    = 1'b1;
        flush    = 1'b1;
        md_ready = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        n_cmp++; if ({multdiv_is_running, multdiv_result_ready, wb_en, timeout, ctrl_mult} !== 5'b0) begin n_bad++; $display("FAIL rst_mid_flags: run/ready/wb_en/to/mult=%b want 00000", {multdiv_is_running, multdiv_result_ready, wb_en, timeout, ctrl_mult}); end
        n_cmp++; if ({wb_rd, wb_data, md_operand_a, md_operand_b} !== 101'd0) begin n_bad++; $display("FAIL rst_mid_data: rd=%0d data=%0h a=%0h b=%0h want all 0", wb_rd, wb_data, md_operand_a, md_operand_b); end
        step();
        md_ready = 1'b0;
        n_cmp++; if ({multdiv_result_ready, wb_en, multdiv_is_running} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_ignore: ready/wb_en/run=%b want 000", {multdiv_result_ready, wb_en, multdiv_is_running}); end
    endtask

    task automatic test_back_to_back();
        issue(ALU_DIV, 5'd12, 32'd100, 32'd7);
        md_ready  = 1'b1;
        md_result = 32'd14;
        step();
        md_ready  = 1'b0;
        md_result = 32'd0;
        n_cmp++; if ({multdiv_result_ready, wb_en, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd12, 32'd14}) begin n_bad++; $display("FAIL b2b_first: ready=%b wb_en=%b rd=%0d data=%0d want 1 1 12 14", multdiv_result_ready, wb_en, wb_rd, wb_data); end
        step();
        issue(ALU_MULT, 5'd13, 32'd5, 32'd5);
        n_cmp++; if ({ctrl_mult, md_operand_a, md_operand_b} !== {1'b1, 32'd5, 32'd5}) begin n_bad++; $display("FAIL b2b_second_start: mult=%b a=%0d b=%0d want 1 5 5", ctrl_mult, md_operand_a, md_operand_b); end
        md_ready  = 1'b1;
        md_result = 32'd25;
        step();
        md_ready  = 1'b0;
        n_cmp++; if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd13, 32'd25}) begin n_bad++; $display("FAIL b2b_second_wb: wb_en=%b rd=%0d data=%0d want 1 13 25", wb_en, wb_rd, wb_data); end
        step();
    endtask

    initial begin
        reset        = 1'b1;
        dx_ir        = 32'd0;
        dx_valid     = 1'b0;
        flush        = 1'b0;
        operand_a    = 32'd0;
        operand_b    = 32'd0;
        md_result    = 32'd0;
        md_exception = 1'b0;
        md_ready     = 1'b0;
        test_reset();
        test_mult_basic();
        test_div_by_zero();
        test_mult_overflow();
        test_rd_zero();
        test_flush();
        test_timeout();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multdiv_controller.md
MULTDIV_CONTROLLER -- requirements
Module: multdiv_controller

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port dx_ir, input, 32 bits: the instruction in the DX stage.
REQ-004 The block SHALL have port dx_valid, input, 1 bit: dx_ir is a real instruction, not a bubble.
REQ-005 The block SHALL have port flush, input, 1 bit: squash of the DX instruction and any in-flight operation.
REQ-006 The block SHALL have ports operand_a and operand_b, inputs, 32 bits each: bypassed DX-stage operands.
REQ-007 The block SHALL have port md_result, input, 32 bits: multdiv unit result.
REQ-008 The block SHALL have port md_exception, input, 1 bit: multdiv unit overflow or divide-by-zero.
REQ-009 The block SHALL have port md_ready, input, 1 bit: the multdiv unit's result is valid.
REQ-010 The block SHALL have ports ctrl_mult and ctrl_div, outputs, 1 bit each: one-cycle start pulses to the unit.
REQ-011 The block SHALL have ports md_operand_a and md_operand_b, outputs, 32 bits each: latched operands, held stable for the whole operation.
REQ-012 The block SHALL have port multdiv_is_running, output, 1 bit: an operation is in flight; this feeds the stall unit.
REQ-013 The block SHALL have port multdiv_result_ready, output, 1 bit: one-cycle completion strobe; the pipeline advances DX on it.
REQ-014 The block SHALL have ports wb_en (1 bit), wb_rd (5 bits) and wb_data (32 bits), outputs: the writeback request.
REQ-015 The block SHALL have port timeout, output, 1 bit: one-cycle watchdog-expiry pulse.

Function
REQ-016 Decode SHALL treat dx_ir as a multdiv op as follows:
- mult when opcode dx_ir[31:27] = 00000 and ALU op dx_ir[6:2] = 00110;
- div when opcode = 00000 and ALU op = 00111;
- rd = dx_ir[26:22].
REQ-017 The FSM SHALL have states IDLE, RUN and DONE; reset state is IDLE.
REQ-018 Acceptance SHALL occur when all of the following hold: state is IDLE, dx_valid = 1, the DX instruction is mult or div, and flush = 0. On acceptance:
- latch operand_a, operand_b, rd and the op type;
- assert ctrl_mult or ctrl_div for exactly the next cycle;
- go to RUN.
REQ-019 In RUN, multdiv_is_running SHALL be 1 and a 6-bit cycle counter SHALL increment each cycle, starting from 0 on entry.
REQ-020 If md_ready = 1 in RUN, the block SHALL capture the writeback and go to DONE:
- md_exception = 0: wb_rd = latched rd, wb_data = md_result;
- md_exception = 1: wb_rd = 30, wb_data = 4 for mult or 5 for div.
REQ-021 In DONE, lasting exactly one cycle:
- multdiv_result_ready SHALL be 1;
- wb_en SHALL be 1, except 0 when wb_rd = 0 and there is no exception;
- the next state SHALL be IDLE.
REQ-022 A multdiv op in DX during the DONE cycle SHALL NOT be accepted; acceptance occurs only from IDLE.
REQ-023 If flush = 1 in RUN, the block SHALL go to IDLE with no writeback; flush SHALL take priority over a simultaneous md_ready.
REQ-024 If the counter reaches 63 in RUN without md_ready, the block SHALL pulse timeout for one cycle and go to IDLE with no writeback.
REQ-025 md_ready or md_exception arriving in IDLE or DONE SHALL be ignored.
REQ-026 ctrl_mult and ctrl_div SHALL never be asserted together, and SHALL never be asserted outside the cycle following acceptance.

Reset
REQ-027 On reset:
- state SHALL be IDLE and the counter 0;
- all 1-bit outputs SHALL be 0;
- wb_rd, wb_data, md_operand_a and md_operand_b SHALL be 0.
REQ-028 Reset mid-operation SHALL abort it with no writeback, overriding flush and md_ready.

Structure
REQ-029 A shared package SHALL hold:
- the state typedef;
- the R-type opcode and the mult and div ALU op codes;
- the rstatus register number (30) and exception codes (4 and 5);
- the timeout limit (63).
REQ-030 The cycle counter SHALL be one sub-module, md_cycle_counter, with clear, enable and 6-bit count; all other logic stays inline.

Verification
REQ-031 The bench SHALL cover at least the following directed scenarios:
- mult 7×6, rd = 5, md_ready at the 17th RUN cycle -> ctrl_mult for 1 cycle; running for 17 cycles; DONE with wb_rd = 5, wb_data = 42, wb_en = 1.
- div by 0 with md_exception = 1 -> wb_rd = 30, wb_data = 5, wb_en = 1.
- mult with rd = 0, no exception -> multdiv_result_ready = 1, wb_en = 0.
- flush and md_ready in the same RUN cycle -> IDLE next cycle, no DONE, wb_en = 0.
- md_ready never asserted -> timeout pulse at counter 63, IDLE, no writeback.
- reset in RUN cycle 3, then md_ready -> IDLE, outputs 0, md_ready ignored.
